branch_redirect_ctrl: RTL and testbench

- Sequences control-flow redirection between the ID-stage branch resolver and the fetch stage.
- Stalls ID while a branch's register operands are not yet forwardable.
- Latches the resolved target, holds it on a valid/ready handshake until fetch accepts it, and tags the delay-slot instruction.
- Keeps taken/not-taken counters for performance monitoring.

---
 rtl/branch_redirect_ctrl.sv | 157 +++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: sits between the ID-stage branch resolver and
// fetch. It stalls ID while a branch waits for its operands, latches taken
// targets into a valid/ready redirect request, tracks the delay slot, and
// keeps saturating taken / not-taken counters.
module branch_redirect_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic                  id_is_branch,
   input  logic                  branch_flag,
   input  logic [ADDR_WIDTH-1:0] branch_addr,
   input  logic                  operand_hazard,
   input  logic                  stall_in,
   input  logic                  flush,
   input  logic                  if_ready,
   output logic                  stall_id,
   output logic                  redirect_valid,
   output logic [ADDR_WIDTH-1:0] redirect_addr,
   output logic                  ds_flag,
   output logic                  ds_branch_err,
   output logic [CNT_WIDTH-1:0]  taken_cnt,
   output logic [CNT_WIDTH-1:0]  not_taken_cnt
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_HAZARD   = 2'd1,
      S_REDIRECT = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic ds_pending;
   logic br_present;
   logic br_eval;
   logic accept_taken;
   logic accept_not_taken;
   logic ds_clear;
   logic ds_err_now;

   // A branch is only a candidate for resolution when it is not itself
   // sitting in a delay slot; delay-slot branches pass as plain instructions.
   assign br_present = id_valid & id_is_branch;
   assign br_eval    = br_present & ~ds_pending;
   assign ds_flag    = ds_pending;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state, combinational stall and per-cycle event decode.
   // HAZARD re-evaluates the held branch exactly as IDLE does once the
   // operands arrive, so both states share one decision path; acceptance is
   // derived without reading stall_id back, since stall_id is necessarily 0
   // whenever a hazard-free branch is being resolved outside REDIRECT.
   always_comb begin
      stall_id         = 1'b0;
      state_next       = state;
      accept_taken     = 1'b0;
      accept_not_taken = 1'b0;
      ds_clear         = 1'b0;
      ds_err_now       = 1'b0;
      if (flush) begin
         state_next = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE, S_HAZARD: begin
               if (br_eval && operand_hazard) begin
                  stall_id   = 1'b1;
                  state_next = S_HAZARD;
               end else begin
                  state_next = S_IDLE;
                  if (br_eval && !stall_in) begin
                     if (branch_flag) begin
                        accept_taken = 1'b1;
                        state_next   = S_REDIRECT;
                     end else begin
                        accept_not_taken = 1'b1;
                     end
                  end
               end
            end
            S_REDIRECT: begin
               // A fresh branch must wait until fetch has taken the
               // outstanding redirect; it is resolved back in IDLE.
               if (br_eval) begin
                  stall_id = 1'b1;
               end
               if (redirect_valid && if_ready) begin
                  state_next = S_IDLE;
               end
            end
            default: begin
               state_next = S_IDLE;
            end
         endcase
         ds_clear   = id_valid && !stall_in && !stall_id;
         ds_err_now = br_present && ds_pending && !stall_in && !stall_id;
      end
   end

   // Redirect request towards fetch; the target is captured only on a taken
   // acceptance and held untouched until the next one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         redirect_valid <= 1'b0;
         redirect_addr  <= '0;
      end else begin
         redirect_valid <= (state_next == S_REDIRECT);
         if (accept_taken) begin
            redirect_addr <= branch_addr;
         end
      end
   end

   // Delay-slot tracking and the registered delay-slot-branch error pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ds_pending    <= 1'b0;
         ds_branch_err <= 1'b0;
      end else begin
         ds_branch_err <= ds_err_now;
         if (flush) begin
            ds_pending <= 1'b0;
         end else if (accept_taken || accept_not_taken) begin
            ds_pending <= 1'b1;
         end else if (ds_clear) begin
            ds_pending <= 1'b0;
         end
      end
   end

   // Saturating performance counters; flush leaves them untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         taken_cnt     <= '0;
         not_taken_cnt <= '0;
      end else begin
         if (accept_taken && (taken_cnt != '1)) begin
            taken_cnt <= taken_cnt + CNT_WIDTH'(1);
         end
         if (accept_not_taken && (not_taken_cnt != '1)) begin
            not_taken_cnt <= not_taken_cnt + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: the driver applies stimulus on
// the falling edge, runs a rule-level model of the controller and queues the
// outputs it expects; an independent monitor pops and compares each cycle.
module tb_branch_redirect_ctrl;

   localparam int unsigned AW = 32;
   localparam int unsigned CW = 4;
   localparam int unsigned CNT_MAX = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic          id_valid;
   logic          id_is_branch;
   logic          branch_flag;
   logic [AW-1:0] branch_addr;
   logic          operand_hazard;
   logic          stall_in;
   logic          flush;
   logic          if_ready;
   logic          stall_id;
   logic          redirect_valid;
   logic [AW-1:0] redirect_addr;
   logic          ds_flag;
   logic          ds_branch_err;
   logic [CW-1:0] taken_cnt;
   logic [CW-1:0] not_taken_cnt;

   branch_redirect_ctrl #(
      .ADDR_WIDTH(AW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .id_valid      (id_valid),
      .id_is_branch  (id_is_branch),
      .branch_flag   (branch_flag),
      .branch_addr   (branch_addr),
      .operand_hazard(operand_hazard),
      .stall_in      (stall_in),
      .flush         (flush),
      .if_ready      (if_ready),
      .stall_id      (stall_id),
      .redirect_valid(redirect_valid),
      .redirect_addr (redirect_addr),
      .ds_flag       (ds_flag),
      .ds_branch_err (ds_branch_err),
      .taken_cnt     (taken_cnt),
      .not_taken_cnt (not_taken_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic          stall;
      logic          rv;
      logic [AW-1:0] addr;
      logic          ds;
      logic          err;
      int unsigned   tk;
      int unsigned   nt;
   } exp_t;

   exp_t exp_q[$];

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Reference model: outstanding redirect, its target, delay-slot flag,
   // registered error pulse and the two counters.
   logic          m_redir;
   logic [AW-1:0] m_addr;
   logic          m_ds;
   logic          m_err;
   int unsigned   m_tk;
   int unsigned   m_nt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
   endtask

   task automatic model_reset();
      m_redir = 1'b0;
      m_addr  = '0;
      m_ds    = 1'b0;
      m_err   = 1'b0;
      m_tk    = 0;
      m_nt    = 0;
   endtask

   // One ID cycle: drive inputs, queue what the DUT should show this cycle,
   // then advance the model to the state after the coming rising edge.
   task automatic step(input logic v, input logic b, input logic t, input logic [AW-1:0] a,
                       input logic h, input logic s, input logic f, input logic r);
      logic br, stall, acc;
      exp_t e;
      @(negedge clk);
      id_valid       = v;
      id_is_branch   = b;
      branch_flag    = t;
      branch_addr    = a;
      operand_hazard = h;
      stall_in       = s;
      flush          = f;
      if_ready       = r;

      br    = v && b;
      // An eligible branch freezes ID while a redirect is outstanding or
      // its operands are missing; a flush overrides everything.
      stall = !f && br && !m_ds && (m_redir || h);
      acc   = br && !h && !s && !stall && !m_ds && !f;

      e.stall = stall;
      e.rv    = m_redir;
      e.addr  = m_addr;
      e.ds    = m_ds;
      e.err   = m_err;
      e.tk    = m_tk;
      e.nt    = m_nt;
      exp_q.push_back(e);

      if (f) begin
         m_redir = 1'b0;
         m_ds    = 1'b0;
         m_err   = 1'b0;
      end else begin
         m_err = br && m_ds && !s && !stall;
         if (acc && t) begin
            m_redir = 1'b1;
            m_addr  = a;
            if (m_tk < CNT_MAX) m_tk++;
         end else if (m_redir && r) begin
            m_redir = 1'b0;
         end
         if (acc && !t && m_nt < CNT_MAX) m_nt++;
         if (acc) m_ds = 1'b1;
         else if (v && !s && !stall) m_ds = 1'b0;
      end
   endtask

   task automatic idle_inputs();
      id_valid       = 1'b0;
      id_is_branch   = 1'b0;
      branch_flag    = 1'b0;
      branch_addr    = '0;
      operand_hazard = 1'b0;
      stall_in       = 1'b0;
      flush          = 1'b0;
      if_ready       = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".stall_id"},       64'(stall_id),       64'd0);
      check({tag, ".redirect_valid"}, 64'(redirect_valid), 64'd0);
      check({tag, ".redirect_addr"},  64'(redirect_addr),  64'd0);
      check({tag, ".ds_flag"},        64'(ds_flag),        64'd0);
      check({tag, ".ds_branch_err"},  64'(ds_branch_err),  64'd0);
      check({tag, ".taken_cnt"},      64'(taken_cnt),      64'd0);
      check({tag, ".not_taken_cnt"},  64'(not_taken_cnt),  64'd0);
   endtask

   // Asynchronous reset asserted between edges, checked before the next edge.
   task automatic async_reset(input string tag);
      @(negedge clk);
      #4;
      idle_inputs();
      rst = 1'b0;
      #0.5;
      check_all_zero(tag);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
   endtask

   // Monitor: compares the DUT against each queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("stall_id",       64'(stall_id),       64'(e.stall));
            check("redirect_valid", 64'(redirect_valid), 64'(e.rv));
            check("redirect_addr",  64'(redirect_addr),  64'(e.addr));
            check("ds_flag",        64'(ds_flag),        64'(e.ds));
            check("ds_branch_err",  64'(ds_branch_err),  64'(e.err));
            check("taken_cnt",      64'(taken_cnt),      64'(e.tk));
            check("not_taken_cnt",  64'(not_taken_cnt),  64'(e.nt));
         end
      end
   end

   initial begin
      rst = 1'b0;
      idle_inputs();
      model_reset();
      #2;
      check_all_zero("por");
      @(negedge clk);
      #1 rst = 1'b1;

      // Taken BEQ with fetch ready, then delay slot and plain instructions.
      step(1, 1, 1, 32'h0040_0020, 0, 0, 0, 1);
      step(1, 0, 0, 32'h0,         0, 0, 0, 1);
      step(1, 0, 0, 32'h0,         0, 0, 0, 1);
      step(0, 0, 0, 32'h0,         0, 0, 0, 1);

      // Taken JAL, fetch busy 3 cycles; second branch waits for handshake.
      step(1, 1, 1, 32'h0000_1234, 0, 0, 0, 0);
      step(1, 0, 0, 32'h0,         0, 0, 0, 0);
      step(1, 1, 0, 32'h0000_5550, 0, 0, 0, 0);
      step(1, 1, 0, 32'h0000_5550, 0, 0, 0, 0);
      step(1, 1, 0, 32'h0000_5550, 0, 0, 0, 1);
      step(1, 1, 0, 32'h0000_5550, 0, 0, 0, 1);
      step(1, 0, 0, 32'h0,         0, 0, 0, 1);

      // BNE waiting 2 cycles for operands, then resolved not taken.
      step(1, 1, 0, 32'h0000_0800, 1, 0, 0, 1);
      step(1, 1, 0, 32'h0000_0800, 1, 0, 0, 1);
      step(1, 1, 0, 32'h0000_0800, 0, 0, 0, 1);
      step(1, 0, 0, 32'h0,         0, 0, 0, 1);

      // Branch sitting in a delay slot.
      step(1, 1, 1, 32'h0000_A000, 0, 0, 0, 1);
      step(1, 1, 1, 32'h0000_B000, 0, 0, 0, 1);
      step(1, 0, 0, 32'h0,         0, 0, 0, 1);
      step(1, 0, 0, 32'h0,         0, 0, 0, 1);

      // Flush in the same cycle as a taken branch.
      step(1, 1, 1, 32'h0000_C000, 0, 0, 1, 1);
      step(1, 0, 0, 32'h0,         0, 0, 0, 1);
      // Flush during an outstanding redirect.
      step(1, 1, 1, 32'h0000_D000, 0, 0, 0, 0);
      step(1, 0, 0, 32'h0,         0, 0, 0, 0);
      step(1, 0, 0, 32'h0,         0, 0, 1, 0);
      step(1, 0, 0, 32'h0,         0, 0, 0, 0);

      // Asynchronous reset while a redirect is outstanding.
      step(1, 1, 1, 32'h0000_E0E0, 0, 0, 0, 0);
      step(1, 0, 0, 32'h0,         0, 0, 0, 0);
      step(0, 0, 0, 32'h0,         0, 0, 0, 0);
      async_reset("rst_mid_redirect");

      // Randomized traffic; the narrow counters reach saturation here.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 9) < 8,
              $urandom_range(0, 9) < 4,
              $urandom_range(0, 1) == 1,
              $urandom & 32'hFFFF_FFFC,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 6) == 0,
              $urandom_range(0, 29) == 0,
              $urandom_range(0, 9) < 6);
      end

      @(negedge clk);
      #3;
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
